// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around uart_tx_arbiter.
// The arbiter uses the slave modport; requesters plus the transmitter use master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_word;
  logic               tx_start;
  logic               tx_ready;
  logic               busy;
  logic               timeout_flag;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, grant, tx_word, tx_start, busy, timeout_flag
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, grant, tx_word, tx_start, busy, timeout_flag
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter, with an idle gap after each packet.
// Optional LOAD stall timeout is built in when TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ    = 3,
  parameter int IDLE_GAP = 15000,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (IDLE_GAP > 0) ? GW'(IDLE_GAP - 1) : '0;

  // state     | meaning
  // S_IDLE    | no owner, searching requesters from ptr+1
  // S_LOAD    | owner granted, waiting for its byte and a ready transmitter
  // S_START   | one-cycle tx_start strobe
  // S_WAIT_*  | waiting for the frame to begin, then to finish
  // S_GAP     | mandatory idle time after a packet
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       word_q, word_d;
  logic             last_q, last_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             accept;
  logic             to_hit;

  assign accept = (state_q == S_LOAD) && bus.tx_ready && bus.req_valid[gidx_q];

  // Search ptr+1, ptr+2, ... ; the nearest valid index wins since it is assigned last.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        pick     = IW'((int'(ptr_q) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TO_MAX  = {TW{1'b1}};

  logic [TW-1:0] to_q, to_d;

  assign to_hit = (state_q == S_LOAD) && !accept && (to_q == TO_LAST);

  always_comb begin
    to_d = '0;
    if (state_q == S_LOAD) to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    word_d  = word_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick;
          grant_d = N_REQ'(1) << pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          word_d  = bus.req_data[8*gidx_q +: 8];
          last_d  = bus.req_last[gidx_q];
          state_d = S_START;
        end else if (to_hit) begin
          ptr_d   = gidx_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_START:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (!bus.tx_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            gap_d   = '0;
            state_d = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      word_q  <= word_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.req_ready    = accept ? grant_q : '0;
  assign bus.grant        = grant_q;
  assign bus.tx_word      = word_q;
  assign bus.tx_start     = (state_q == S_START);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.timeout_flag = to_hit;
endmodule
